// File: rtl/serial_nibble_deserializer.sv
// rtl/serial_nibble_deserializer.sv - framed serial-to-parallel receiver with valid/ready output
// Start bit, DATA_W data bits, stop bit; flags framing errors and dropped frames.
module serial_nibble_deserializer #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_STOP    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                complete;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          if (MSB_FIRST)
            shift_d = (shift_q << 1) | DATA_W'(sin);
          else
            shift_d = (shift_q >> 1) | (DATA_W'(sin) << (DATA_W - 1));
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1))
            state_d = S_STOP;
        end
        S_STOP: begin
          if (sin) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_RECOVER;
          end
        end
        default: begin
          // A low stop bit is never treated as a start; wait for the line to go high.
          if (sin)
            state_d = S_IDLE;
        end
      endcase
    end

    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// tb/tb_serial_nibble_deserializer.sv - scoreboard bench for serial_nibble_deserializer
// Directed frames; a negedge monitor pops expected words whenever a new word is presented.
module tb_serial_nibble_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en;
  logic       sin;
  logic       dout_ready;
  logic [3:0] dout_l, dout_m;
  logic       valid_l, valid_m;
  logic       busy_l, busy_m;
  logic       ferr_l, ferr_m;
  logic       ovr_l, ovr_m;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  logic [3:0] q_lsb[$];
  logic [3:0] q_msb[$];

  always #5 clk = ~clk;

  serial_nibble_deserializer #(.DATA_W(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .sin(sin),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l)
  );

  serial_nibble_deserializer #(.DATA_W(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .sin(sin),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a word is newly presented when valid rises or reloads right after a transfer.
  logic prev_valid_l = 1'b0, prev_xfer_l = 1'b0;
  logic prev_valid_m = 1'b0, prev_xfer_m = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid_l = 1'b0; prev_xfer_l = 1'b0;
      prev_valid_m = 1'b0; prev_xfer_m = 1'b0;
    end else begin
      if (valid_l && (!prev_valid_l || prev_xfer_l)) begin
        if (q_lsb.size() == 0) check("lsb_unexpected_word", {28'd0, dout_l}, 32'hFFFF_FFFF);
        else check("lsb_word", {28'd0, dout_l}, {28'd0, q_lsb.pop_front()});
      end
      if (valid_m && (!prev_valid_m || prev_xfer_m)) begin
        if (q_msb.size() == 0) check("msb_unexpected_word", {28'd0, dout_m}, 32'hFFFF_FFFF);
        else check("msb_word", {28'd0, dout_m}, {28'd0, q_msb.pop_front()});
      end
      if (ferr_l) ferr_cnt++;
      if (ovr_l) ovr_cnt++;
      prev_valid_l = valid_l; prev_xfer_l = valid_l && dout_ready;
      prev_valid_m = valid_m; prev_xfer_m = valid_m && dout_ready;
    end
  end

  task automatic drive(input logic en, input logic s);
    bit_en = en;
    sin    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] v, input logic stop);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, v[i]);
    drive(1'b1, stop);
  endtask

  task automatic consume();
    bit_en     = 1'b0;
    sin        = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    check("valid_l_after_xfer", {31'd0, valid_l}, 32'd0);
    check("valid_m_after_xfer", {31'd0, valid_m}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    bit_en     = 1'b0;
    sin        = 1'b1;
    dout_ready = 1'b0;
    #2;
    check("rst_dout", {28'd0, dout_l}, 32'd0);
    check("rst_valid", {31'd0, valid_l}, 32'd0);
    check("rst_busy", {31'd0, busy_l}, 32'd0);
    check("rst_ferr_ovr", {30'd0, ferr_l, ovr_l}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b1);

    // Frame D: LSB-first instance 4'hD, MSB-first instance 4'hB; latency check.
    q_lsb.push_back(4'hD); q_msb.push_back(4'hB);
    drive(1'b1, 1'b0);
    check("busy_after_start", {31'd0, busy_l}, 32'd1);
    drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    check("valid_before_stop", {31'd0, valid_l}, 32'd0);
    drive(1'b1, 1'b1);
    check("valid_after_stop", {31'd0, valid_l}, 32'd1);
    check("busy_after_stop", {31'd0, busy_l}, 32'd0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    check("ferr_ovr_none", ferr_cnt + ovr_cnt, 32'd0);
    consume();

    // Back-to-back 4'h3 then 4'hA with no ready: second is dropped.
    q_lsb.push_back(4'h3); q_msb.push_back(4'hC);
    send_frame(4'h3, 1'b1);
    send_frame(4'hA, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    check("overrun_once", ovr_cnt, 32'd1);
    check("held_dout_l", {28'd0, dout_l}, 32'h3);
    check("held_dout_m", {28'd0, dout_m}, 32'hC);
    consume();

    // Framing error, then low samples must not start a frame.
    send_frame(4'h5, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    check("busy_recover", {31'd0, busy_l}, 32'd1);
    check("ferr_once", ferr_cnt, 32'd1);
    check("valid_after_ferr", {31'd0, valid_l}, 32'd0);
    drive(1'b1, 1'b1);
    check("idle_after_recover", {31'd0, busy_l}, 32'd0);
    q_lsb.push_back(4'h9); q_msb.push_back(4'h9);
    send_frame(4'h9, 1'b1);
    drive(1'b0, 1'b1);
    consume();

    // bit_en every third cycle; line toggles on disabled cycles must be ignored.
    q_lsb.push_back(4'h6); q_msb.push_back(4'h6);
    begin
      logic [5:0] bits;
      bits = {1'b1, 4'h6, 1'b0};
      for (int i = 0; i < 6; i++) begin
        drive(1'b1, bits[i]);
        drive(1'b0, ~bits[i]);
        drive(1'b0, ~bits[i]);
        if (i == 2) check("busy_frozen", {31'd0, busy_l}, 32'd1);
      end
    end
    check("slow_valid", {31'd0, valid_l}, 32'd1);
    consume();

    // Reset after two data bits.
    drive(1'b1, 1'b0); drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_dout_l", {28'd0, dout_l}, 32'd0);
    check("midrst_dout_m", {28'd0, dout_m}, 32'd0);
    check("midrst_busy", {31'd0, busy_l}, 32'd0);
    check("midrst_valid", {31'd0, valid_l}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b1);
    q_lsb.push_back(4'h9); q_msb.push_back(4'h9);
    send_frame(4'h9, 1'b1);
    drive(1'b0, 1'b1);
    consume();

    repeat (3) drive(1'b0, 1'b1);
    check("final_ferr_cnt", ferr_cnt, 32'd1);
    check("final_ovr_cnt", ovr_cnt, 32'd1);
    check("lsb_queue_empty", q_lsb.size(), 32'd0);
    check("msb_queue_empty", q_msb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_nibble_deserializer.md
# serial_nibble_deserializer

Upstream stage for the 4-bit parallel register: receives a framed, idle-high serial bit stream (start bit, DATA_W data bits, stop bit), assembles the data bits into a parallel word and presents it with a valid/ready handshake. The downstream 4-bit register loads `dout` on an accepted transfer. The block also flags framing errors and overruns.

## Interface
- `DATA_W`, default 4: data bits per frame and width of `dout`.
- `MSB_FIRST`, default 0: 0 means the first received data bit lands in `dout[0]`; 1 means it lands in `dout[DATA_W-1]`.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `bit_en`  in  1: bit-time strobe; `sin` is sampled only on cycles with `bit_en`=1.
- `sin`  in  1: serial line; idles at 1.
- `dout`  out  DATA_W: assembled word; stable while `dout_valid`=1.
- `dout_valid`  out  1: `dout` holds an unconsumed word.
- `dout_ready`  in  1: downstream accepts; a transfer occurs on a cycle with `dout_valid`=1 and `dout_ready`=1.
- `busy`  out  1: FSM is not in IDLE.
- `frame_err`  out  1: one-cycle pulse; stop bit was sampled as 0.
- `overrun`  out  1: one-cycle pulse; a completed frame was dropped.

## Operation
- States: IDLE, DATA, STOP, RECOVER. Bit counter width is clog2(DATA_W).
- IDLE: on `bit_en`, `sin`=0 (start bit) -> DATA, counter=0. On `bit_en` with `sin`=1, stay in IDLE.
- DATA: on each `bit_en`, shift `sin` into the shift register per `MSB_FIRST` and increment the counter. After the DATA_W-th sample -> STOP.
- STOP: on `bit_en`, `sin`=1 means the frame is complete -> IDLE. `sin`=0 means framing error: pulse `frame_err`, discard the word -> RECOVER.
- RECOVER: wait for a `bit_en` sample with `sin`=1, then -> IDLE. A 0 stop bit is never reinterpreted as a start bit.
- Frame completion when `dout_valid`=0: load `dout` from the shift register and set `dout_valid`=1.
- Frame completion when `dout_valid`=1 and `dout_ready`=1 in the same cycle: the old word transfers, the new word loads, and `dout_valid` stays 1. No overrun.
- Frame completion when `dout_valid`=1 and `dout_ready`=0: keep the old `dout`, drop the new word, pulse `overrun`.
- Transfer with no completion in that cycle: `dout_valid` goes to 0 next cycle. `dout` keeps its last value.
- `bit_en`=0: the FSM, counter and shift register hold. The handshake continues independently of `bit_en`.
- Reset mid-frame: the partial word is lost and the FSM returns to IDLE.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0. Internal: state=IDLE, shift register=0, counter=0.
- All outputs are registered. No combinational path from `dout_ready` or `sin` to any output.
- Latency: `dout_valid` rises on the clock edge that samples the stop bit, i.e. it is visible the cycle after that `bit_en` cycle. With `bit_en` tied high, a frame takes DATA_W+2 cycles from start-bit sample to `dout_valid`.
- `frame_err` and `overrun` are high for exactly the one cycle following the offending stop-bit sample.
- `busy` is high from the cycle after the start-bit sample until the cycle after the stop-bit sample. It is also high throughout RECOVER.
- Back-to-back frames: a start bit may be sampled on the `bit_en` immediately after a valid stop bit.

## Test plan
- Reset, then `bit_en`=1 with `sin` bits 0,1,0,1,1,1 (start, data LSB-first 1,0,1,1, stop), `dout_ready`=0 -> `dout`=4'hD and `dout_valid`=1 six cycles after the start sample. `frame_err` and `overrun` stay 0.
- Same stream with `MSB_FIRST`=1 -> `dout`=4'hB.
- Two back-to-back frames 4'h3 then 4'hA with `dout_ready`=0 -> `dout` holds 4'h3 and `overrun` pulses once. Then raise `dout_ready` -> one transfer and `dout_valid` falls.
- Frame with stop bit 0 -> `frame_err` pulses once and `dout_valid` stays 0. Following `sin`=0 samples do not start a frame until one `sin`=1 sample occurs.
- `bit_en` asserted every 3rd cycle, frame 4'h6 -> `dout`=4'h6. State is frozen on cycles with `bit_en`=0.
- Assert `reset` after 2 data bits -> all outputs 0 immediately. The next full frame 4'h9 is received correctly.
